// File: rtl/scie_dispatch_if.sv
// scie_dispatch_if: core-side, SCIE-side and writeback signals of the dispatch stage.
// The master modport is the environment (core plus SCIE unit); slave is the dispatch block.
// Valid/ready on the input and writeback sides; the SCIE side has no backpressure.
interface scie_dispatch_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_insn;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;

  logic        scie_valid;
  logic [31:0] scie_insn;
  logic [31:0] scie_rs1;
  logic [31:0] scie_rs2;
  logic [31:0] scie_rd;

  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data;
  logic        wb_err;

  modport master (
    output in_valid, in_insn, in_rs1, in_rs2, scie_rd, wb_ready,
    input  in_ready, scie_valid, scie_insn, scie_rs1, scie_rs2,
           wb_valid, wb_rd_addr, wb_data, wb_err
  );

  modport slave (
    input  in_valid, in_insn, in_rs1, in_rs2, scie_rd, wb_ready,
    output in_ready, scie_valid, scie_insn, scie_rs1, scie_rs2,
           wb_valid, wb_rd_addr, wb_data, wb_err
  );
endinterface

// File: rtl/scie_dispatch.sv
// scie_dispatch: in-order issue/writeback stage in front of the non-stalling SCIE unit.
// Latency: push to issue 1 cycle (0 when bypassing), issue to wb_valid LATENCY+1 cycles.
// Backpressure: in_ready falls when the input FIFO is full; issue stalls when in-flight plus
// buffered results reach RDEPTH. Optional macro SCIE_DISPATCH_BYPASS_EN enables same-cycle
// issue from in_* when the input FIFO is empty.
module scie_dispatch #(
  parameter int DEPTH   = 4,
  parameter int RDEPTH  = 4,
  parameter int LATENCY = 1
) (
  input logic            clock,
  input logic            reset,
  scie_dispatch_if.slave bus
);
  localparam int IAW = $clog2(DEPTH);
  localparam int ICW = IAW + 1;
  localparam int RAW = $clog2(RDEPTH);
  localparam int RCW = RAW + 1;
  localparam logic [ICW-1:0] IFULL = ICW'(DEPTH);
  localparam logic [RCW:0]   RLIM  = (RCW + 1)'(RDEPTH);

  // input FIFO storage and state
  logic [31:0]    iq_insn [DEPTH];
  logic [31:0]    iq_rs1  [DEPTH];
  logic [31:0]    iq_rs2  [DEPTH];
  logic [IAW-1:0] iq_wp, iq_rp;
  logic [ICW-1:0] iq_cnt, iq_cnt_nxt;
  logic           in_full;
  logic           iq_empty, iq_push, iq_pop;

  // issue-side selection
  logic [31:0] hd_insn, hd_rs1, hd_rs2;
  logic        hd_legal, bypass, issue, credit;

  // tag pipeline tracking SCIE latency
  logic [LATENCY-1:0] tag_vld;
  logic               tag_err [LATENCY];
  logic [4:0]         tag_rd  [LATENCY];
  logic [RCW-1:0]     inflight;

  // result FIFO
  logic           rq_err [RDEPTH];
  logic [4:0]     rq_rd  [RDEPTH];
  logic [31:0]    rq_dat [RDEPTH];
  logic [RAW-1:0] rq_wp, rq_rp;
  logic [RCW-1:0] rq_cnt, rq_cnt_nxt;
  logic           rq_push, rq_pop;
  logic [31:0]    rq_wdat;

  assign iq_empty     = (iq_cnt == '0);
  assign bus.in_ready = !in_full;

  // credit check uses registered counts only, so a same-cycle wb pop frees credit next cycle
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + RCW'(tag_vld[i]);
    end
    credit = (({1'b0, inflight} + {1'b0, rq_cnt}) < RLIM);
  end

  // pick the issue candidate, decode it and decide push/pop of the input FIFO
  always_comb begin
    hd_insn = iq_insn[iq_rp];
    hd_rs1  = iq_rs1[iq_rp];
    hd_rs2  = iq_rs2[iq_rp];
    bypass  = 1'b0;
`ifdef SCIE_DISPATCH_BYPASS_EN
    if (iq_empty && bus.in_valid && credit) begin
      bypass  = 1'b1;
      hd_insn = bus.in_insn;
      hd_rs1  = bus.in_rs1;
      hd_rs2  = bus.in_rs2;
    end
`endif
    issue    = credit && (!iq_empty || bypass);
    iq_pop   = issue && !iq_empty;
    iq_push  = bus.in_valid && !in_full && !bypass;
    hd_legal = (hd_insn[6:0] == 7'h0B) || (hd_insn[6:0] == 7'h2B);
  end

  // SCIE-facing outputs are zero whenever nothing legal issues
  assign bus.scie_valid = issue && hd_legal;
  assign bus.scie_insn  = bus.scie_valid ? hd_insn : 32'h0;
  assign bus.scie_rs1   = bus.scie_valid ? hd_rs1  : 32'h0;
  assign bus.scie_rs2   = bus.scie_valid ? hd_rs2  : 32'h0;

  // next occupancy of the input FIFO
  always_comb begin
    iq_cnt_nxt = iq_cnt;
    if (iq_push && !iq_pop) iq_cnt_nxt = iq_cnt + ICW'(1);
    if (!iq_push && iq_pop) iq_cnt_nxt = iq_cnt - ICW'(1);
  end

  // input FIFO pointers, count and registered full flag
  always_ff @(posedge clock) begin
    if (reset) begin
      iq_wp   <= '0;
      iq_rp   <= '0;
      iq_cnt  <= '0;
      in_full <= 1'b0;
    end else begin
      if (iq_push) iq_wp <= iq_wp + IAW'(1);
      if (iq_pop)  iq_rp <= iq_rp + IAW'(1);
      iq_cnt  <= iq_cnt_nxt;
      in_full <= (iq_cnt_nxt == IFULL);
    end
  end

  // input FIFO payload write
  always_ff @(posedge clock) begin
    if (iq_push) begin
      iq_insn[iq_wp] <= bus.in_insn;
      iq_rs1[iq_wp]  <= bus.in_rs1;
      iq_rs2[iq_wp]  <= bus.in_rs2;
    end
  end

  // tag valid bits; clearing them on reset drops any SCIE results still in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_vld <= '0;
    end else begin
      tag_vld[0] <= issue;
      for (int i = 1; i < LATENCY; i++) begin
        tag_vld[i] <= tag_vld[i-1];
      end
    end
  end

  // tag payload follows the valid bits through the latency pipeline
  always_ff @(posedge clock) begin
    tag_err[0] <= !hd_legal;
    tag_rd[0]  <= hd_insn[11:7];
    for (int i = 1; i < LATENCY; i++) begin
      tag_err[i] <= tag_err[i-1];
      tag_rd[i]  <= tag_rd[i-1];
    end
  end

  assign rq_push = tag_vld[LATENCY-1];
  assign rq_wdat = (tag_err[LATENCY-1] || (tag_rd[LATENCY-1] == 5'd0)) ? 32'h0 : bus.scie_rd;
  assign rq_pop  = bus.wb_valid && bus.wb_ready;

  // next occupancy of the result FIFO
  always_comb begin
    rq_cnt_nxt = rq_cnt;
    if (rq_push && !rq_pop) rq_cnt_nxt = rq_cnt + RCW'(1);
    if (!rq_push && rq_pop) rq_cnt_nxt = rq_cnt - RCW'(1);
  end

  // result FIFO pointers and count
  always_ff @(posedge clock) begin
    if (reset) begin
      rq_wp  <= '0;
      rq_rp  <= '0;
      rq_cnt <= '0;
    end else begin
      if (rq_push) rq_wp <= rq_wp + RAW'(1);
      if (rq_pop)  rq_rp <= rq_rp + RAW'(1);
      rq_cnt <= rq_cnt_nxt;
    end
  end

  // result FIFO payload write
  always_ff @(posedge clock) begin
    if (rq_push) begin
      rq_err[rq_wp] <= tag_err[LATENCY-1];
      rq_rd[rq_wp]  <= tag_rd[LATENCY-1];
      rq_dat[rq_wp] <= rq_wdat;
    end
  end

  // writeback outputs read zero while the result FIFO is empty
  assign bus.wb_valid   = (rq_cnt != '0);
  assign bus.wb_rd_addr = bus.wb_valid ? rq_rd[rq_rp]  : 5'd0;
  assign bus.wb_data    = bus.wb_valid ? rq_dat[rq_rp] : 32'h0;
  assign bus.wb_err     = bus.wb_valid && rq_err[rq_rp];
endmodule

// File: tb/tb_scie_dispatch.sv
// tb_scie_dispatch: directed stimulus against scie_dispatch with a LATENCY=1 rs1+rs2 SCIE model.
// A queue-based model predicts every writeback and every legal issue in program order.
// Directed phases pin the model with literal values, latencies and backpressure limits.
module tb_scie_dispatch;
  localparam int DEPTH   = 4;
  localparam int RDEPTH  = 4;
  localparam int LATENCY = 1;
`ifdef SCIE_DISPATCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  scie_dispatch_if dif();

  scie_dispatch #(.DEPTH(DEPTH), .RDEPTH(RDEPTH), .LATENCY(LATENCY)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (dif)
  );

  // SCIE unit model: one register stage returning rs1+rs2
  always @(posedge clock) dif.scie_rd <= dif.scie_rs1 + dif.scie_rs2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
  } wb_t;

  wb_t          exp_q[$];
  logic [95:0]  iss_q[$];
  logic [4:0]   got_rd[$];
  logic [31:0]  got_data[$];
  logic         got_err[$];
  int           got_cyc[$];
  int n_wb = 0, n_scie = 0, n_wbv = 0, push_cyc = 0, issue_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // monitor: feed the model from accepted inputs, compare issues and writebacks
  wb_t         m_e;
  logic [95:0] m_x;
  logic        m_legal;
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      iss_q.delete();
    end else begin
      if (dif.in_valid && dif.in_ready) begin
        m_legal  = (dif.in_insn[6:0] == 7'h0B) || (dif.in_insn[6:0] == 7'h2B);
        m_e.rd   = dif.in_insn[11:7];
        m_e.err  = !m_legal;
        m_e.data = (m_legal && m_e.rd != 5'd0) ? dif.in_rs1 + dif.in_rs2 : 32'h0;
        exp_q.push_back(m_e);
        if (m_legal) iss_q.push_back({dif.in_insn, dif.in_rs1, dif.in_rs2});
        push_cyc = cyc;
      end
      if (dif.scie_valid) begin
        n_scie++;
        issue_cyc = cyc;
        if (iss_q.size() == 0) fail_now("scie_unexpected_issue");
        else begin
          m_x = iss_q.pop_front();
          check("scie_insn", dif.scie_insn, m_x[95:64]);
          check("scie_rs1",  dif.scie_rs1,  m_x[63:32]);
          check("scie_rs2",  dif.scie_rs2,  m_x[31:0]);
        end
      end else begin
        check("scie_idle_zero", dif.scie_insn | dif.scie_rs1 | dif.scie_rs2, 32'h0);
      end
      if (dif.wb_valid) n_wbv++;
      if (dif.wb_valid && dif.wb_ready) begin
        n_wb++;
        got_rd.push_back(dif.wb_rd_addr);
        got_data.push_back(dif.wb_data);
        got_err.push_back(dif.wb_err);
        got_cyc.push_back(cyc);
        if (exp_q.size() == 0) fail_now("wb_unexpected");
        else begin
          m_e = exp_q.pop_front();
          check("wb_rd_addr", 32'(dif.wb_rd_addr), 32'(m_e.rd));
          check("wb_data",    dif.wb_data,         m_e.data);
          check("wb_err",     32'(dif.wb_err),     32'(m_e.err));
        end
      end
    end
  end

  task automatic align();
    @(posedge clock);
    #1;
  endtask

  // present one instruction from posedge+1 and hold it until accepted
  task automatic send(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
    int k;
    dif.in_valid = 1'b1;
    dif.in_insn  = insn;
    dif.in_rs1   = rs1;
    dif.in_rs2   = rs2;
    k = 0;
    @(negedge clock);
    while (!dif.in_ready && k < 200) begin
      @(negedge clock);
      k++;
    end
    if (!dif.in_ready) fail_now("send_timeout");
    align();
    dif.in_valid = 1'b0;
  endtask

  task automatic wait_wb(input int n);
    int k;
    k = 0;
    while (n_wb < n && k < 200) begin
      @(negedge clock);
      k++;
    end
    if (n_wb < n) fail_now("wb_timeout");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},   32'(dif.in_ready),   32'd1);
    check({tag, "_scie_valid"}, 32'(dif.scie_valid), 32'd0);
    check({tag, "_scie_insn"},  dif.scie_insn,       32'h0);
    check({tag, "_scie_rs1"},   dif.scie_rs1,        32'h0);
    check({tag, "_scie_rs2"},   dif.scie_rs2,        32'h0);
    check({tag, "_wb_valid"},   32'(dif.wb_valid),   32'd0);
    check({tag, "_wb_rd_addr"}, 32'(dif.wb_rd_addr), 32'd0);
    check({tag, "_wb_data"},    dif.wb_data,         32'h0);
    check({tag, "_wb_err"},     32'(dif.wb_err),     32'd0);
  endtask

  logic [31:0] s_rs1 [5] = '{32'd24, 32'd82, 32'd17, 32'd4, 32'd35};
  logic [31:0] s_rs2 [5] = '{32'd1,  32'd2,  32'd3,  32'd4, 32'd0};
  logic [31:0] s_exp [5] = '{32'd25, 32'd84, 32'd20, 32'd8, 32'd35};

  initial begin
    int base, sc0, snap;
    reset        = 1'b1;
    dif.in_valid = 1'b0;
    dif.in_insn  = 32'h0;
    dif.in_rs1   = 32'h0;
    dif.in_rs2   = 32'h0;
    dif.wb_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check_reset_outputs("reset");
    align();
    reset = 1'b0;

    // single legal instruction
    base = n_wb;
    sc0  = n_scie;
    send(32'h0000_008B, 32'd9, 32'd0);
    wait_wb(base + 1);
    check("single_issues", 32'(n_scie - sc0), 32'd1);
    if (n_wb > base) begin
      check("single_rd",   32'(got_rd[base]),   32'd1);
      check("single_data", got_data[base],      32'd9);
      check("single_err",  32'(got_err[base]),  32'd0);
      check("single_issue_lat", 32'(issue_cyc - push_cyc),     32'(1 - BYP));
      check("single_wb_lat",    32'(got_cyc[base] - push_cyc), 32'(3 - BYP));
    end
    align();

    // back-to-back stream, one writeback per cycle
    base = n_wb;
    for (int i = 0; i < 5; i++) send({20'h0, 5'(i + 1), 7'h0B}, s_rs1[i], s_rs2[i]);
    wait_wb(base + 5);
    if (n_wb >= base + 5) begin
      for (int i = 0; i < 5; i++) begin
        check("stream_rd",   32'(got_rd[base + i]), 32'(i + 1));
        check("stream_data", got_data[base + i],    s_exp[i]);
        if (i > 0) check("stream_rate", 32'(got_cyc[base + i] - got_cyc[base + i - 1]), 32'd1);
      end
    end
    align();

    // legal then illegal opcode: illegal never reaches SCIE, returns in order with err
    base = n_wb;
    sc0  = n_scie;
    send(32'h0000_018B, 32'd1, 32'd1);
    send(32'h0000_015B, 32'd3, 32'd4);
    wait_wb(base + 2);
    check("illegal_issues", 32'(n_scie - sc0), 32'd1);
    if (n_wb >= base + 2) begin
      check("prior_rd",     32'(got_rd[base]),      32'd3);
      check("prior_data",   got_data[base],         32'd2);
      check("illegal_rd",   32'(got_rd[base + 1]),  32'd2);
      check("illegal_data", got_data[base + 1],     32'd0);
      check("illegal_err",  32'(got_err[base + 1]), 32'd1);
    end
    align();

    // rd=0: issued, but written back as zero
    base = n_wb;
    sc0  = n_scie;
    send(32'h0000_000B, 32'd5, 32'd6);
    wait_wb(base + 1);
    check("rd0_issues", 32'(n_scie - sc0), 32'd1);
    if (n_wb > base) begin
      check("rd0_rd",   32'(got_rd[base]),  32'd0);
      check("rd0_data", got_data[base],     32'd0);
      check("rd0_err",  32'(got_err[base]), 32'd0);
    end
    align();

    // backpressure: RDEPTH issues, then DEPTH buffered, then in_ready low
    base = n_wb;
    sc0  = n_scie;
    dif.wb_ready = 1'b0;
    for (int i = 0; i < 8; i++) send({20'h0, 5'(i + 1), 7'h0B}, 32'(i * 3), 32'd100);
    dif.in_valid = 1'b1;
    dif.in_insn  = {20'h0, 5'd9, 7'h0B};
    dif.in_rs1   = 32'd24;
    dif.in_rs2   = 32'd100;
    repeat (10) @(negedge clock);
    check("bp_in_ready",   32'(dif.in_ready),  32'd0);
    check("bp_issues",     32'(n_scie - sc0),  32'(RDEPTH));
    check("bp_scie_valid", 32'(dif.scie_valid), 32'd0);
    check("bp_no_wb",      32'(n_wb - base),   32'd0);
    align();
    dif.wb_ready = 1'b1;
    send({20'h0, 5'd9, 7'h0B}, 32'd24, 32'd100);
    send({20'h0, 5'd10, 7'h0B}, 32'd27, 32'd100);
    wait_wb(base + 10);
    check("bp_total_issues", 32'(n_scie - sc0), 32'd10);
    if (n_wb >= base + 10) begin
      for (int i = 0; i < 10; i++) begin
        check("bp_order_rd", 32'(got_rd[base + i]), 32'(i + 1));
        check("bp_data",     got_data[base + i],    32'(i * 3 + 100));
      end
    end
    check("model_drained", 32'(exp_q.size()), 32'd0);
    align();

    // reset with entries buffered and in flight
    dif.wb_ready = 1'b0;
    send(32'h0000_008B, 32'd1, 32'd2);
    send(32'h0000_010B, 32'd3, 32'd4);
    send(32'h0000_018B, 32'd5, 32'd6);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check_reset_outputs("midreset");
    align();
    reset        = 1'b0;
    dif.wb_ready = 1'b1;
    snap = n_wbv;
    repeat (8) @(negedge clock);
    check("no_stale_wb", 32'(n_wbv - snap), 32'd0);
    align();

    // recovery with a custom-1 instruction
    base = n_wb;
    send(32'h0000_01AB, 32'd7, 32'd8);
    wait_wb(base + 1);
    if (n_wb > base) begin
      check("recover_rd",   32'(got_rd[base]),  32'd3);
      check("recover_data", got_data[base],     32'd15);
      check("recover_err",  32'(got_err[base]), 32'd0);
    end
    repeat (3) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule
